// File: rtl/uart_pkg.sv
// Shared UART transmit types, frame constants and a width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Bits needed to index 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Serialises one byte as 8N1: START, 8 data bits LSB first, STOP.
// Latency: txd falls at the edge that samples start; frame lasts 10*BAUD_DIV cycles.
// Backpressure: start is honoured only in IDLE; busy covers START through STOP.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 108
) (
    input  logic                      osc_clk,
    input  logic                      osc_reset,
    input  logic                      start,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      busy,
    output logic                      done,
    output logic                      txd
);

    localparam int CW = clog2(BAUD_DIV);
    localparam int IW = clog2(UART_FRAME_BITS - 2);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      txd_q, txd_d;
    logic                      bit_end;

    assign bit_end = (cnt_q == '0);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == STOP) && bit_end;
    assign txd     = txd_q;

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    // txd is registered, so each branch sets the level for the next bit slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (start) begin
                    state_d = START;
                    cnt_d   = BAUD_LOAD;
                    shreg_d = data;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = BAUD_LOAD;
                    idx_d   = '0;
                    txd_d   = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = BAUD_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        txd_d = shreg_q[idx_q + 1'b1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of a single 8N1 transmitter.
// Latency: byte accepted in cycle N drives the start bit from N+1; one IDLE cycle between frames.
// Backpressure: req_ready is a one-cycle strobe, only while the transmitter is idle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NR_REQ       = 3,
    parameter int BAUD_DIV     = 108,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                      osc_clk,
    input  logic                      osc_reset,
    input  logic [NR_REQ-1:0]         req_valid,
    input  logic [8*NR_REQ-1:0]       req_data,
    input  logic [NR_REQ-1:0]         req_last,
    output logic [NR_REQ-1:0]         req_ready,
    output logic                      uart_txd,
    output logic                      busy,
    output logic [clog2(NR_REQ)-1:0]  grant_id,
    output logic                      locked
);

    localparam int GW = clog2(NR_REQ);
    localparam int TW = clog2(LOCK_TIMEOUT);
    localparam logic [GW-1:0] LAST_REQ = GW'(NR_REQ - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);

    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] win;
    logic [TW-1:0] lock_cnt;
    logic [7:0]    win_data;
    logic          have;
    logic          accept;
    logic          tx_done;
    logic          lock_wait;
    logic          timeout_fire;

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
        return (i == LAST_REQ) ? '0 : i + 1'b1;
    endfunction

    // While locked only the current grantee is eligible; otherwise first valid from rr_ptr.
    always_comb begin
        int j;
        j    = 0;
        win  = grant_id;
        have = 1'b0;
        if (locked) begin
            have = req_valid[grant_id];
        end else begin
            for (int k = 0; k < NR_REQ; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= NR_REQ) begin
                    j = j - NR_REQ;
                end
                if (!have && req_valid[j]) begin
                    have = 1'b1;
                    win  = GW'(j);
                end
            end
        end
    end

    assign accept       = have && !busy && !osc_reset;
    assign win_data     = req_data[8*win +: 8];
    assign lock_wait    = !busy && locked && !req_valid[grant_id];
    assign timeout_fire = (LOCK_TIMEOUT != 0) && lock_wait && (lock_cnt == TO_LAST);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            grant_id <= '0;
            locked   <= 1'b0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else begin
            if (accept) begin
                grant_id <= win;
                locked   <= !req_last[win];
                if (req_last[win]) begin
                    rr_ptr <= next_idx(win);
                end
            end else if (timeout_fire) begin
                locked <= 1'b0;
                rr_ptr <= next_idx(grant_id);
            end
            // The idle window restarts at each accept and each frame end.
            if (accept || timeout_fire || tx_done) begin
                lock_cnt <= '0;
            end else if (lock_wait) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    uart_tx_shifter #(
        .BAUD_DIV (BAUD_DIV)
    ) u_shifter (
        .osc_clk   (osc_clk),
        .osc_reset (osc_reset),
        .start     (accept),
        .data      (win_data),
        .busy      (busy),
        .done      (tx_done),
        .txd       (uart_txd)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, framing, round-robin, locking, timeout, mid-frame reset.
module tb_uart_tx_arbiter;

    localparam int NR_REQ       = 3;
    localparam int BAUD_DIV     = 4;
    localparam int LOCK_TIMEOUT = 16;

    logic          osc_clk;
    logic          osc_reset;
    logic [2:0]    req_valid;
    logic [23:0]   req_data;
    logic [2:0]    req_last;
    logic [2:0]    req_ready;
    logic          uart_txd;
    logic          busy;
    logic [1:0]    grant_id;
    logic          locked;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NR_REQ       (NR_REQ),
        .BAUD_DIV     (BAUD_DIV),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .osc_clk   (osc_clk),
        .osc_reset (osc_reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .uart_txd  (uart_txd),
        .busy      (busy),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic wait_accept(input int budget, output logic [2:0] rdy, output int waited);
        waited = 0;
        while (req_ready == 3'b000 && waited < budget) begin
            tick();
            #1;
            waited++;
        end
        rdy = req_ready;
        check("accept_seen", {31'd0, (rdy != 3'b000)}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            #1;
            n++;
        end
        check("idle_seen", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        int slot;
        slot = i / BAUD_DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return d[slot-1];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_seq;
        logic [2:0] rdy;
        logic [2:0] rr_exp [4];
        logic [1:0] gid_exp [4];
        int         waited;

        a5_seq     = 10'b1101001010;
        rr_exp[0]  = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        gid_exp[0] = 2'd0;   gid_exp[1] = 2'd1;  gid_exp[2] = 2'd2;  gid_exp[3] = 2'd0;

        osc_reset = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset held 20 cycles with no requests.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_txd", uart_txd, 1);
            check("reset_busy", busy, 0);
            check("reset_ready", req_ready, 0);
        end
        check("reset_grant", grant_id, 0);
        check("reset_locked", locked, 0);
        osc_reset = 1'b0;

        // Single byte 0xA5 from req0.
        req_data[7:0] = 8'hA5;
        req_last      = 3'b001;
        req_valid     = 3'b001;
        #1;
        check("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        for (int i = 0; i < 10*BAUD_DIV; i++) begin
            check("single_txd", uart_txd, a5_seq[i/BAUD_DIV]);
            check("single_busy", busy, 1);
            check("single_noready", req_ready, 0);
            tick();
        end
        check("single_idle_txd", uart_txd, 1);
        check("single_idle_busy", busy, 0);
        check("single_grant", grant_id, 0);
        check("single_locked", locked, 0);

        // Round-robin from reset with every requester valid.
        osc_reset = 1'b1;
        tick();
        osc_reset = 1'b0;
        req_data  = {8'h33, 8'h22, 8'h11};
        req_last  = 3'b111;
        req_valid = 3'b111;
        #1;
        for (int g = 0; g < 4; g++) begin
            wait_accept(60, rdy, waited);
            check("rr_grant", rdy, rr_exp[g]);
            check("rr_gap", waited, (g == 0) ? 0 : 10*BAUD_DIV);
            tick();
            #1;
            check("rr_start_txd", uart_txd, 0);
            check("rr_one_strobe", req_ready, 0);
            check("rr_grant_id", grant_id, gid_exp[g]);
        end
        req_valid = '0;
        #1;
        wait_idle(60);

        // Packet lock: three bytes from req1 while req0/req2 stay valid.
        req_data  = {8'h33, 8'hB1, 8'h11};
        req_last  = 3'b101;
        req_valid = 3'b111;
        #1;
        wait_accept(5, rdy, waited);
        check("lock_b1_grant", rdy, 3'b010);
        check("lock_b1_wait", waited, 0);
        tick();
        #1;
        check("lock_b1_locked", locked, 1);
        check("lock_b1_gid", grant_id, 1);
        req_data[15:8] = 8'hB2;
        #1;
        wait_accept(60, rdy, waited);
        check("lock_b2_grant", rdy, 3'b010);
        check("lock_b2_gap", waited, 10*BAUD_DIV);
        tick();
        #1;
        check("lock_b2_locked", locked, 1);
        req_data[15:8] = 8'hB3;
        req_last       = 3'b111;
        #1;
        wait_accept(60, rdy, waited);
        check("lock_b3_grant", rdy, 3'b010);
        check("lock_b3_gap", waited, 10*BAUD_DIV);
        tick();
        #1;
        check("lock_b3_released", locked, 0);
        wait_accept(60, rdy, waited);
        check("lock_next_grant", rdy, 3'b100);
        check("lock_next_gap", waited, 10*BAUD_DIV);
        tick();
        req_valid = '0;
        #1;
        check("lock_next_gid", grant_id, 2);
        wait_idle(60);

        // Lock timeout: req0 opens a packet then goes quiet, req1 waits.
        req_data  = {8'h00, 8'h37, 8'h5A};
        req_last  = 3'b010;
        req_valid = 3'b011;
        #1;
        wait_accept(5, rdy, waited);
        check("to_first_grant", rdy, 3'b001);
        tick();
        req_valid = 3'b010;
        #1;
        check("to_locked", locked, 1);
        check("to_gid", grant_id, 0);
        for (int i = 0; i < 10*BAUD_DIV - 1; i++) tick();
        check("to_last_stop_busy", busy, 1);
        tick();
        #1;
        check("to_frame_end_busy", busy, 0);
        for (int i = 1; i <= LOCK_TIMEOUT; i++) begin
            check("to_hold_ready", req_ready, 0);
            check("to_hold_locked", locked, 1);
            tick();
            #1;
        end
        check("to_release_locked", locked, 0);
        check("to_release_grant", req_ready, 3'b010);

        // Reset during data bit 3 of req1's byte 0x37 (bit3 = 0).
        tick();
        req_valid = '0;
        #1;
        check("mid_start_txd", uart_txd, 0);
        for (int i = 0; i < 17; i++) tick();
        check("mid_bit3_txd", uart_txd, 0);
        check("mid_bit3_busy", busy, 1);
        osc_reset = 1'b1;
        tick();
        osc_reset = 1'b0;
        #1;
        check("mid_reset_txd", uart_txd, 1);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_locked", locked, 0);
        check("mid_reset_gid", grant_id, 0);
        req_data  = {8'h99, 8'h88, 8'h3C};
        req_last  = 3'b111;
        req_valid = 3'b111;
        #1;
        check("mid_restart_grant", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        for (int i = 0; i < 10*BAUD_DIV; i++) begin
            check("mid_restart_txd", uart_txd, frame_bit(8'h3C, i));
            tick();
        end
        check("mid_restart_idle", busy, 0);
        check("mid_restart_line", uart_txd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
